// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle serial subtractor, STEP bits per clock, LSB first
// Optional OVF output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  d_sh;
    logic              borrow;
    logic [CW-1:0]     cnt;
    logic [STEP-1:0]   step_d;
    logic              bw;
    logic [WIDTH-1:0]  d_next;
    logic              last_step;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic              a_msb;
    logic              b_msb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Ripple of STEP full-subtractor cells fed by the borrow saved last cycle.
    always_comb begin
        bw     = borrow;
        step_d = '0;
        for (int i = 0; i < STEP; i++) begin
            step_d[i] = a_sh[i] ^ b_sh[i] ^ bw;
            bw        = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & bw);
        end
    end

    // Difference bits enter at the top so that after NSTEPS shifts they sit in place.
    always_comb begin
        d_next    = (d_sh >> STEP) | (WIDTH'(step_d) << (WIDTH - STEP));
        last_step = (state == RUN) && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            OVF    <= 1'b0;
`endif
        end else begin
            done <= last_step;
            if (state == IDLE && start) begin
                a_sh   <= A;
                b_sh   <= B;
                d_sh   <= '0;
                borrow <= Bin;
                cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                a_msb  <= A[WIDTH-1];
                b_msb  <= B[WIDTH-1];
`endif
            end else if (state == RUN) begin
                a_sh   <= a_sh >> STEP;
                b_sh   <= b_sh >> STEP;
                d_sh   <= d_next;
                borrow <= bw;
                cnt    <= cnt + 1'b1;
                if (last_step) begin
                    D    <= d_next;
                    Bout <= bw;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    OVF  <= (a_msb != b_msb) && (d_next[WIDTH-1] != a_msb);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (STEP=1 and STEP=4 instances)
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         when;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic       bin1 = 1'b0, bin4 = 1'b0;
    logic       busy1, done1, bo1, busy4, done4, bo4;
    logic [7:0] d1, d4;
    logic       ov1 = 1'b0, ov4 = 1'b0;

    exp_t       sb[2][$];
    logic [7:0] last_d[2];
    logic       last_bo[2];
    int         ncyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Bin(bin1),
        .busy(busy1), .done(done1), .D(d1), .Bout(bo1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .OVF(ov1)
`endif
    );

    serial_subtractor #(.WIDTH(8), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Bin(bin4),
        .busy(busy4), .done(done4), .D(d4), .Bout(bo4)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .OVF(ov4)
`endif
    );

    task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, s, act, exp);
        end
    endtask

    task automatic mon(input int s, input logic dn, input logic bz, input logic [7:0] d,
                       input logic bo, input logic ov);
        exp_t e;
        if (rst) begin
            last_d[s]  = '0;
            last_bo[s] = 1'b0;
        end else if (dn) begin
            if (sb[s].size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_done dut%0d: got done=1 expected no pending result", s);
            end else begin
                e = sb[s].pop_front();
                chk("latency", s, ncyc, e.when);
                chk("d", s, 32'(d), 32'(e.d));
                chk("bout", s, 32'(bo), 32'(e.bo));
                chk("busy_in_done", s, 32'(bz), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                chk("ovf", s, 32'(ov), 32'(e.ov));
`endif
                last_d[s]  = e.d;
                last_bo[s] = e.bo;
            end
        end else begin
            chk("d_hold", s, 32'(d), 32'(last_d[s]));
            chk("bout_hold", s, 32'(bo), 32'(last_bo[s]));
        end
        if (ov === 1'bx) chk("ovf_known", s, 32'(ov), 32'd0);
    endtask

    always @(negedge clk) begin
        ncyc++;
        mon(0, done1, busy1, d1, bo1, ov1);
        mon(1, done4, busy4, d4, bo4, ov4);
    end

    task automatic wait_neg(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Called at negedge+1; holds start for one edge, then scrambles operands.
    task automatic issue(input int s, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic [7:0] ed, input logic ebo, input logic eov);
        exp_t e;
        e.d = ed;
        e.bo = ebo;
        e.ov = eov;
        e.when = ncyc + ((s == 0) ? 8 : 2) + 1;
        if (s == 0) begin
            start1 = 1'b1; a1 = a; b1 = b; bin1 = bin;
        end else begin
            start4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
        end
        sb[s].push_back(e);
        wait_neg(1);
        if (s == 0) begin
            start1 = 1'b0; a1 = ~a; b1 = ~b; bin1 = ~bin;
        end else begin
            start4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin;
        end
    endtask

    initial begin
        int bin;
        wait_neg(2);
        chk("rst_busy", 0, 32'(busy1), 0);
        chk("rst_done", 0, 32'(done1), 0);
        chk("rst_d", 0, 32'(d1), 0);
        chk("rst_bout", 0, 32'(bo1), 0);
        chk("rst_busy", 1, 32'(busy4), 0);
        chk("rst_d", 1, 32'(d4), 0);
        rst = 1'b0;
        wait_neg(2);

        issue(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", 0, 32'(busy1), 1);
            wait_neg(1);
        end
        wait_neg(2);

        issue(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        wait_neg(8);
        issue(0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        wait_neg(10);

        issue(0, 8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 1'b0);
        wait_neg(2);
        start1 = 1'b1; a1 = 8'hFF; b1 = 8'h00; bin1 = 1'b0;
        wait_neg(1);
        start1 = 1'b0;
        wait_neg(14);

        issue(0, 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0);
        void'(sb[0].pop_back());
        wait_neg(3);
        chk("busy_mid", 0, 32'(busy1), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 0, 32'(busy1), 0);
        chk("abort_done", 0, 32'(done1), 0);
        chk("abort_d", 0, 32'(d1), 0);
        chk("abort_bout", 0, 32'(bo1), 0);
        wait_neg(2);
        rst = 1'b0;
        wait_neg(12);

        issue(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        wait_neg(8);
        issue(0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        wait_neg(10);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bin = (a ^ b) & 1;
                issue(1, 8'(a), 8'(b), 1'(bin), 8'((a - b - bin) & 255), (a < b + bin), 1'b0);
                wait_neg(2);
            end
        end
        issue(1, 8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0);
        wait_neg(2);

        for (int i = 0; i < 30 && (sb[0].size() != 0 || sb[1].size() != 0); i++) wait_neg(1);
        chk("drain", 0, 32'(sb[0].size()), 0);
        chk("drain", 1, 32'(sb[1].size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter STEP, default 1, bits processed per clock; WIDTH SHALL be an integer multiple of STEP.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a subtraction.
REQ-006 SHALL have port A  input  WIDTH  minuend, sampled on accepted start.
REQ-007 SHALL have port B  input  WIDTH  subtrahend, sampled on accepted start.
REQ-008 SHALL have port Bin  input  1  borrow-in, sampled on accepted start.
REQ-009 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when D/Bout are updated.
REQ-011 SHALL have port D  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH.
REQ-012 SHALL have port Bout  output  1  final borrow-out (1 when A < B + Bin, unsigned).

Function
REQ-013 SHALL implement a two-state FSM: IDLE, RUN.
REQ-014 IDLE: start=1 at clock edge SHALL latch A, B, Bin into internal shift registers, clear step counter, go to RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN: each cycle SHALL process the next STEP bits LSB-first as a ripple of STEP full-subtractor cells (d = a^b^bi, bo = ~a&b | ~(a^b)&bi), registering the borrow between cycles.
REQ-016 After exactly WIDTH/STEP RUN cycles, the FSM SHALL load D and Bout, assert done for one cycle, and return to IDLE on that same edge.
REQ-017 Latency SHALL be WIDTH/STEP cycles: start accepted at edge k gives done=1 and valid D/Bout in the cycle following edge k+WIDTH/STEP.
REQ-018 busy SHALL be 1 exactly while the FSM is in RUN; busy SHALL be 0 in the done cycle.
REQ-019 start while busy=1 SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-020 start in the done cycle SHALL be accepted (back-to-back operation, no idle gap).
REQ-021 D and Bout SHALL change only on completion and SHALL hold their values between completions; intermediate bits SHALL NOT appear on D.
REQ-022 A, B, Bin changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-023 rst=1 SHALL immediately force FSM to IDLE, busy=0, done=0, D=0, Bout=0, and clear internal shift registers, borrow and counter.
REQ-024 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Configuration
REQ-025 Macro SERIAL_SUBTRACTOR_OVF_EN defined SHALL add output port OVF (1 bit), loaded with D on completion: 1 when the two's-complement result of A - B - Bin overflows (sign of A differs from sign of B and sign of D differs from sign of A); reset value 0.
REQ-026 Without SERIAL_SUBTRACTOR_OVF_EN, port OVF and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-027 WIDTH=8, STEP=1: A=0x05, B=0x03, Bin=0, start one cycle -> busy 8 cycles, then done=1, D=0x02, Bout=0.
REQ-028 WIDTH=8, STEP=1: A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1; then back-to-back start in done cycle with A=0xFF, B=0xFF, Bin=1 -> D=0xFF, Bout=1, 8 cycles later.
REQ-029 WIDTH=8, STEP=4: exhaustive low nibble sweep plus A=0x3C, B=0x5A, Bin=1 -> done 2 cycles after start, D=0xE1, Bout=1.
REQ-030 Start pulsed with new operands at cycle 3 of RUN -> ignored; result matches original operands; no extra done.
REQ-031 rst asserted at cycle 4 of RUN -> busy=0, done=0, D=0x00, Bout=0 immediately; no done pulse follows.
REQ-032 With SERIAL_SUBTRACTOR_OVF_EN, WIDTH=8: A=0x80, B=0x01, Bin=0 -> D=0x7F, Bout=0, OVF=1; A=0x10, B=0x01 -> OVF=0.
